// File: rtl/ysyx_24110006_trap_ctrl_pkg.sv
// rtl/ysyx_24110006_trap_ctrl_pkg.sv - shared cause codes and FSM encodings for the trap controller
package ysyx_24110006_trap_ctrl_pkg;

    // Exception/interrupt code field of mcause; the interrupt flag is the MSB
    // and is added by the priority encoder so the codes stay XLEN-independent.
    localparam int CODE_W = 4;
    typedef logic [CODE_W-1:0] code_t;

    localparam code_t CAUSE_IFAULT  = 4'd1;
    localparam code_t CAUSE_ILLEGAL = 4'd2;
    localparam code_t CAUSE_EBREAK  = 4'd3;
    localparam code_t CAUSE_LMIS    = 4'd4;
    localparam code_t CAUSE_SMIS    = 4'd6;
    localparam code_t CAUSE_MTI     = 4'd7;
    localparam code_t CAUSE_ECALL_M = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/ysyx_24110006_trap_prio.sv
// rtl/ysyx_24110006_trap_prio.sv - combinational trap source priority encoder
// Ports: i_irq and the retire fault flags in; o_take (some trap source active)
// and o_mcause (full mcause value, interrupt flag in the MSB) out.
module ysyx_24110006_trap_prio
    import ysyx_24110006_trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_irq,
    input  logic            i_ifault,
    input  logic            i_illegal,
    input  logic            i_ebreak,
    input  logic            i_ecall,
    input  logic            i_lmisalign,
    input  logic            i_smisalign,
    output logic            o_take,
    output logic [XLEN-1:0] o_mcause
);

    code_t code;
    logic  is_int;

    always_comb begin
        code   = '0;
        is_int = 1'b0;
        o_take = 1'b1;
        if (i_irq) begin
            code   = CAUSE_MTI;
            is_int = 1'b1;
        end else if (i_ifault) begin
            code = CAUSE_IFAULT;
        end else if (i_illegal) begin
            code = CAUSE_ILLEGAL;
        end else if (i_ebreak) begin
            code = CAUSE_EBREAK;
        end else if (i_ecall) begin
            code = CAUSE_ECALL_M;
        end else if (i_lmisalign) begin
            code = CAUSE_LMIS;
        end else if (i_smisalign) begin
            code = CAUSE_SMIS;
        end else begin
            o_take = 1'b0;
        end
    end

    assign o_mcause = {is_int, {(XLEN-1-CODE_W){1'b0}}, code};

endmodule

// File: rtl/ysyx_24110006_trap_ctrl.sv
// rtl/ysyx_24110006_trap_ctrl.sv - machine-mode trap initiator between retire point, CSR file and IFU
// Ports: retire handshake (i_retire_valid/o_retire_ready, pc, fault flags, mret),
// interrupt enables (i_mie/i_mtie/i_mtip), CSR write strobe (o_csr_*) with the
// CSR target i_csr_upc, flush plus redirect handshake to the IFU, and a
// saturating count of traps taken.
module ysyx_24110006_trap_ctrl
    import ysyx_24110006_trap_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_retire_valid,
    output logic             o_retire_ready,
    input  logic [XLEN-1:0]  i_retire_pc,
    input  logic             i_ifault,
    input  logic             i_illegal,
    input  logic             i_ecall,
    input  logic             i_ebreak,
    input  logic             i_lmisalign,
    input  logic             i_smisalign,
    input  logic             i_mret,
    input  logic             i_mie,
    input  logic             i_mtie,
    input  logic             i_mtip,
    output logic             o_csr_valid,
    output logic             o_csr_exception,
    output logic             o_csr_mret,
    output logic [XLEN-1:0]  o_csr_mcause,
    output logic [XLEN-1:0]  o_csr_pc,
    input  logic [XLEN-1:0]  i_csr_upc,
    output logic             o_flush,
    output logic             o_redirect_valid,
    input  logic             i_redirect_ready,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic [CNT_W-1:0] o_trap_count
);

    state_t            state, state_nxt;
    logic              take;
    logic [XLEN-1:0]   mcause;
    logic              hs;
    logic              start;
    logic [XLEN-1:0]   cause_q;
    logic [XLEN-1:0]   pc_q;
    logic              trap_q;
    logic              mret_q;
    logic [XLEN-1:0]   redir_q;
    logic [CNT_W-1:0]  cnt_q;

    // The timer interrupt is only considered here, i.e. while IDLE; a pending
    // rise during COMMIT/REDIRECT waits for the next retiring instruction.
    ysyx_24110006_trap_prio #(.XLEN(XLEN)) u_prio (
        .i_irq       (i_mtip & i_mtie & i_mie),
        .i_ifault    (i_ifault),
        .i_illegal   (i_illegal),
        .i_ebreak    (i_ebreak),
        .i_ecall     (i_ecall),
        .i_lmisalign (i_lmisalign),
        .i_smisalign (i_smisalign),
        .o_take      (take),
        .o_mcause    (mcause)
    );

    assign hs    = (state == ST_IDLE) && i_retire_valid;
    assign start = hs && (take || i_mret);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_COMMIT;
            ST_COMMIT:   state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (i_redirect_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cause_q <= '0;
            pc_q    <= '0;
            trap_q  <= 1'b0;
            mret_q  <= 1'b0;
            redir_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (start) begin
                // A trap source wins over mret, so mret is only remembered alone.
                cause_q <= take ? mcause : '0;
                pc_q    <= i_retire_pc;
                trap_q  <= take;
                mret_q  <= ~take & i_mret;
            end
            if (state == ST_COMMIT) begin
                redir_q <= i_csr_upc;
                if (trap_q && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_retire_ready   = 1'b0;
        o_csr_valid      = 1'b0;
        o_csr_exception  = 1'b0;
        o_csr_mret       = 1'b0;
        o_csr_mcause     = '0;
        o_csr_pc         = '0;
        o_flush          = 1'b0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        case (state)
            ST_IDLE: begin
                o_retire_ready = 1'b1;
            end
            ST_COMMIT: begin
                o_csr_valid     = 1'b1;
                o_flush         = 1'b1;
                o_csr_exception = trap_q;
                o_csr_mret      = mret_q;
                o_csr_mcause    = cause_q;
                o_csr_pc        = pc_q;
            end
            ST_REDIRECT: begin
                o_flush          = 1'b1;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = redir_q;
            end
            default: begin
                o_retire_ready = 1'b0;
            end
        endcase
    end

    assign o_trap_count = cnt_q;

endmodule

// File: tb/tb_ysyx_24110006_trap_ctrl.sv
// tb/tb_ysyx_24110006_trap_ctrl.sv - scoreboard bench for the trap controller
module tb_ysyx_24110006_trap_ctrl;

    localparam int F_IFAULT = 0, F_ILLEGAL = 1, F_ECALL = 2, F_EBREAK = 3, F_LMIS = 4;
    localparam int F_SMIS = 5, F_MRET = 6, F_MIE = 7, F_MTIE = 8, F_MTIP = 9;

    typedef struct packed {
        logic        exc;
        logic        mret;
        logic [31:0] cause;
        logic [31:0] pc;
    } csr_exp_t;

    logic        i_clock = 1'b0;
    logic        i_reset_n;
    logic        i_retire_valid;
    logic        o_retire_ready;
    logic [31:0] i_retire_pc;
    logic        i_ifault, i_illegal, i_ecall, i_ebreak, i_lmisalign, i_smisalign, i_mret;
    logic        i_mie, i_mtie, i_mtip;
    logic        o_csr_valid, o_csr_exception, o_csr_mret;
    logic [31:0] o_csr_mcause, o_csr_pc, i_csr_upc;
    logic        o_flush, o_redirect_valid, i_redirect_ready;
    logic [31:0] o_redirect_pc;
    logic [15:0] o_trap_count;

    int          total = 0;
    int          bad   = 0;
    int          exp_count = 0;
    csr_exp_t    csr_q[$];
    logic [31:0] redir_q[$];
    csr_exp_t    ce;
    logic [31:0] re;

    always #5 i_clock = ~i_clock;

    ysyx_24110006_trap_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .i_clock          (i_clock),
        .i_reset_n        (i_reset_n),
        .i_retire_valid   (i_retire_valid),
        .o_retire_ready   (o_retire_ready),
        .i_retire_pc      (i_retire_pc),
        .i_ifault         (i_ifault),
        .i_illegal        (i_illegal),
        .i_ecall          (i_ecall),
        .i_ebreak         (i_ebreak),
        .i_lmisalign      (i_lmisalign),
        .i_smisalign      (i_smisalign),
        .i_mret           (i_mret),
        .i_mie            (i_mie),
        .i_mtie           (i_mtie),
        .i_mtip           (i_mtip),
        .o_csr_valid      (o_csr_valid),
        .o_csr_exception  (o_csr_exception),
        .o_csr_mret       (o_csr_mret),
        .o_csr_mcause     (o_csr_mcause),
        .o_csr_pc         (o_csr_pc),
        .i_csr_upc        (i_csr_upc),
        .o_flush          (o_flush),
        .o_redirect_valid (o_redirect_valid),
        .i_redirect_ready (i_redirect_ready),
        .o_redirect_pc    (o_redirect_pc),
        .o_trap_count     (o_trap_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_flags(input logic [9:0] f);
        i_ifault    = f[F_IFAULT];
        i_illegal   = f[F_ILLEGAL];
        i_ecall     = f[F_ECALL];
        i_ebreak    = f[F_EBREAK];
        i_lmisalign = f[F_LMIS];
        i_smisalign = f[F_SMIS];
        i_mret      = f[F_MRET];
        i_mie       = f[F_MIE];
        i_mtie      = f[F_MTIE];
        i_mtip      = f[F_MTIP];
    endtask

    // kind: 0 = no trap expected, 1 = exception, 2 = mret.
    // Returns on the negedge where the first redirect cycle is expected.
    task automatic issue(input logic [9:0] f, input logic [31:0] pc, input logic [31:0] upc,
                         input int kind, input logic [31:0] cause);
        csr_exp_t e;
        @(posedge i_clock); #1;
        apply_flags(f);
        i_retire_pc    = pc;
        i_csr_upc      = upc;
        i_retire_valid = 1'b1;
        if (kind != 0) begin
            e.exc   = (kind == 1);
            e.mret  = (kind == 2);
            e.cause = cause;
            e.pc    = pc;
            csr_q.push_back(e);
            redir_q.push_back(upc);
        end
        @(negedge i_clock);
        check("retire_ready_idle", o_retire_ready, 1);
        @(posedge i_clock); #1;
        apply_flags('0);
        i_retire_valid = 1'b0;
        @(negedge i_clock);
        check("csr_latency", o_csr_valid, (kind != 0));
        check("flush_commit", o_flush, (kind != 0));
        @(negedge i_clock);
        check("redirect_latency", o_redirect_valid, (kind != 0));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (o_retire_ready) break;
            @(negedge i_clock);
        end
        check("idle_timeout", o_retire_ready, 1);
    endtask

    always @(negedge i_clock) begin
        if (i_reset_n) begin
            if (o_csr_valid) begin
                if (csr_q.size() == 0) begin
                    check("csr_unexpected", o_csr_valid, 0);
                end else begin
                    ce = csr_q.pop_front();
                    check("csr_exception", o_csr_exception, ce.exc);
                    check("csr_mret", o_csr_mret, ce.mret);
                    if (ce.exc) begin
                        check("csr_mcause", o_csr_mcause, ce.cause);
                        check("csr_pc", o_csr_pc, ce.pc);
                    end
                end
            end
            if (o_redirect_valid && i_redirect_ready) begin
                if (redir_q.size() == 0) begin
                    check("redirect_unexpected", o_redirect_valid, 0);
                end else begin
                    re = redir_q.pop_front();
                    check("redirect_pc", o_redirect_pc, re);
                end
            end
        end
    end

    initial begin
        i_reset_n        = 1'b0;
        i_retire_valid   = 1'b0;
        i_retire_pc      = '0;
        i_csr_upc        = '0;
        i_redirect_ready = 1'b1;
        apply_flags('0);
        repeat (2) @(posedge i_clock);
        #1 i_reset_n = 1'b1;
        @(negedge i_clock);
        check("rst_retire_ready", o_retire_ready, 1);
        check("rst_csr_valid", o_csr_valid, 0);
        check("rst_redirect_valid", o_redirect_valid, 0);
        check("rst_flush", o_flush, 0);
        check("rst_count", o_trap_count, 0);

        // basic ecall
        issue(10'(1 << F_ECALL), 32'h8000_0010, 32'h8000_0100, 1, 32'd11);
        check("redirect_pc_first", o_redirect_pc, 32'h8000_0100);
        wait_idle(); exp_count = 1;
        check("count_ecall", o_trap_count, exp_count);

        // priority: illegal beats ecall and smisalign, ifault beats all
        issue(10'((1 << F_ILLEGAL) | (1 << F_ECALL) | (1 << F_SMIS)), 32'h8000_0020, 32'h8000_0100, 1, 32'd2);
        wait_idle(); exp_count = 2;
        issue(10'((1 << F_IFAULT) | (1 << F_ILLEGAL) | (1 << F_ECALL) | (1 << F_SMIS)), 32'h8000_0024, 32'h8000_0100, 1, 32'd1);
        wait_idle(); exp_count = 3;
        check("count_prio", o_trap_count, exp_count);

        // mret alone does not count
        issue(10'(1 << F_MRET), 32'h8000_0100, 32'h8000_0014, 2, 32'd0);
        wait_idle();
        check("count_mret", o_trap_count, exp_count);

        // mret beaten by illegal
        issue(10'((1 << F_MRET) | (1 << F_ILLEGAL)), 32'h8000_0104, 32'h8000_0100, 1, 32'd2);
        wait_idle(); exp_count = 4;

        // timer interrupt gated by MIE, then taken
        issue(10'((1 << F_ECALL) | (1 << F_MTIP) | (1 << F_MTIE)), 32'h8000_0030, 32'h8000_0100, 1, 32'd11);
        wait_idle(); exp_count = 5;
        issue(10'((1 << F_ECALL) | (1 << F_MTIP) | (1 << F_MTIE) | (1 << F_MIE)), 32'h8000_0040, 32'h8000_0100, 1, 32'h8000_0007);
        wait_idle(); exp_count = 6;

        // retire with no trap source: nothing happens
        issue('0, 32'h8000_0044, 32'h8000_0100, 0, 32'd0);
        wait_idle();
        check("count_notrap", o_trap_count, exp_count);

        issue(10'(1 << F_LMIS), 32'h8000_0048, 32'h8000_0100, 1, 32'd4);
        wait_idle(); exp_count = 7;

        // backpressure on the redirect
        i_redirect_ready = 1'b0;
        issue(10'(1 << F_EBREAK), 32'h8000_0050, 32'h8000_0180, 1, 32'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clock);
            check("bp_valid", o_redirect_valid, 1);
            check("bp_pc", o_redirect_pc, 32'h8000_0180);
            check("bp_retire_ready", o_retire_ready, 0);
            check("bp_flush", o_flush, 1);
        end
        @(posedge i_clock); #1 i_redirect_ready = 1'b1;
        @(negedge i_clock);
        @(negedge i_clock);
        check("bp_idle_ready", o_retire_ready, 1);
        check("bp_valid_drop", o_redirect_valid, 0);
        exp_count = 8;
        check("count_bp", o_trap_count, exp_count);

        // reset while in REDIRECT drops the redirect
        i_redirect_ready = 1'b0;
        issue(10'(1 << F_SMIS), 32'h8000_0060, 32'h8000_0200, 1, 32'd6);
        @(negedge i_clock);
        #2 i_reset_n = 1'b0;
        #1;
        check("arst_redirect_valid", o_redirect_valid, 0);
        check("arst_redirect_pc", o_redirect_pc, 0);
        check("arst_flush", o_flush, 0);
        check("arst_csr_valid", o_csr_valid, 0);
        check("arst_retire_ready", o_retire_ready, 1);
        check("arst_count", o_trap_count, 0);
        csr_q.delete();
        redir_q.delete();
        exp_count = 0;
        @(posedge i_clock); #1;
        i_redirect_ready = 1'b1;
        i_reset_n = 1'b1;

        issue(10'(1 << F_ECALL), 32'h8000_0070, 32'h8000_0100, 1, 32'd11);
        wait_idle(); exp_count = 1;
        check("count_after_reset", o_trap_count, exp_count);

        repeat (2) @(negedge i_clock);
        check("csr_q_left", csr_q.size(), 0);
        check("redir_q_left", redir_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_24110006_trap_ctrl.md
Name: ysyx_24110006_trap_ctrl

Overview:
- Trap initiator for the machine-mode CSR file.
- Sits between the retire point of the core (IDU/EXU/LSU fault flags) and the CSR block.
- Prioritises retire-time exceptions, the machine timer interrupt and mret into one trap request per instruction. Drives the CSR file's exception, mcause, pc and mret inputs, and samples the CSR's upc.
- Issues a flush plus a valid/ready redirect to the IFU.

Parameters:
- XLEN, 32, datapath width for pc, mcause and redirect.
- CNT_W, 16, width of the saturating trap counter.

Ports:
- i_clock  input  1  core clock.
- i_reset_n  input  1  reset, asynchronous, active-low.
- i_retire_valid  input  1  one instruction is at the retire point.
- o_retire_ready  output  1  controller accepts the retiring instruction.
- i_retire_pc  input  XLEN  pc of the retiring instruction.
- i_ifault  input  1  instruction access fault.
- i_illegal  input  1  illegal instruction.
- i_ecall  input  1  ecall decoded.
- i_ebreak  input  1  ebreak decoded.
- i_lmisalign  input  1  load address misaligned.
- i_smisalign  input  1  store address misaligned.
- i_mret  input  1  mret decoded.
- i_mie  input  1  mstatus.MIE.
- i_mtie  input  1  mie.MTIE.
- i_mtip  input  1  timer interrupt pending (level).
- o_csr_valid  output  1  CSR write strobe.
- o_csr_exception  output  1  trap entry.
- o_csr_mret  output  1  trap return.
- o_csr_mcause  output  XLEN  cause value.
- o_csr_pc  output  XLEN  value written to mepc.
- i_csr_upc  input  XLEN  CSR target: mtvec on exception, mepc on mret.
- o_flush  output  1  kill younger instructions.
- o_redirect_valid  output  1  redirect pc is valid.
- i_redirect_ready  input  1  IFU accepts the redirect.
- o_redirect_pc  output  XLEN  new fetch pc.
- o_trap_count  output  CNT_W  number of traps taken, saturating.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE.
  - All outputs 0, except o_retire_ready=1.
  - Counter 0.
- States: IDLE, COMMIT, REDIRECT.
- IDLE:
  - o_retire_ready=1.
  - Handshake when i_retire_valid=1.
  - Cause selection, highest priority first:
    - interrupt (i_mtip & i_mtie & i_mie): mcause 0x80000007.
    - ifault: 1.
    - illegal: 2.
    - ebreak: 3.
    - ecall: 11.
    - lmisalign: 4.
    - smisalign: 6.
  - Cause and i_retire_pc are registered, then go to COMMIT.
  - mret with no trap source: register mret, go to COMMIT.
  - Neither trap nor mret: stay in IDLE, no outputs.
- COMMIT, exactly 1 cycle:
  - o_csr_valid=1, o_flush=1.
  - Drives o_csr_exception or o_csr_mret, never both; trap beats mret.
  - o_csr_mcause and o_csr_pc are driven from the registers.
  - i_csr_upc is sampled into the redirect register at the clock edge.
  - Go to REDIRECT.
  - o_retire_ready=0.
  - o_trap_count increments on trap (not on mret) and saturates at all-ones.
- REDIRECT:
  - o_redirect_valid=1 and o_redirect_pc held stable until i_redirect_ready=1.
  - On the accepting cycle: return to IDLE; o_redirect_valid drops the next cycle.
  - o_retire_ready=0.
  - o_flush=1 throughout.
- Latency: retire handshake to o_csr_valid is 1 cycle; to first o_redirect_valid is 2 cycles.
- o_csr_valid is asserted only in COMMIT. The CSR block is therefore written exactly once per trap.
- Interrupts are sampled only in IDLE. An mtip rise during COMMIT/REDIRECT is taken on the next retire.
- Reset asserted in any state: immediate return to IDLE.
  - Pending redirect is dropped.
  - No CSR strobe is generated.

Decomposition:
- Shared package holds:
  - mcause constants: CAUSE_IFAULT, CAUSE_ILLEGAL, CAUSE_EBREAK, CAUSE_ECALL_M, CAUSE_LMIS, CAUSE_SMIS, CAUSE_MTI.
  - State encodings.
- One natural sub-module: ysyx_24110006_trap_prio. Combinational priority encoder: flags in, take+mcause out.

Test Plan:
- Basic ecall:
  - Stimulus: i_ecall at pc 0x80000010, i_csr_upc=0x80000100, ready=1.
  - Response: o_csr_valid one cycle with mcause=11 and o_csr_pc=0x80000010. Redirect to 0x80000100 two cycles after the handshake. trap_count=1.
- Exception priority:
  - Stimulus: i_illegal+i_ecall+i_smisalign together.
  - Response: mcause=2. With i_ifault also set: mcause=1.
- mret:
  - Stimulus: i_mret, i_csr_upc=0x80000014.
  - Response: o_csr_mret=1, o_csr_exception=0, redirect 0x80000014, trap_count unchanged.
- mret beaten by a trap:
  - Stimulus: i_mret+i_illegal.
  - Response: exception only, mcause=2.
- Timer interrupt gating:
  - Stimulus: i_mtip=1, i_mtie=1, i_mie=0 on an ecall.
  - Response: mcause=11.
  - Stimulus: i_mie=1 on the same ecall.
  - Response: mcause=0x80000007, mepc=retire pc.
- Backpressure and reset:
  - Stimulus: i_redirect_ready=0 for 5 cycles.
  - Response: o_redirect_valid and pc stable, o_retire_ready=0. Then ready=1 gives IDLE next cycle.
  - Stimulus: i_reset_n low while in REDIRECT.
  - Response: all outputs 0 asynchronously, counter 0.
